// File: rtl/npu_result_rd_scheduler_if.sv
// -----------------------------------------------------------------------------
// npu_result_rd_scheduler_if
// Bundles the signals between the result read scheduler, the NPU channel read
// port and the result sink.
//   save_finish / ch_en         : start request and channel enable mask
//   rd_sop / rd_eop / rd_vld    : per-channel read-start pulse, last-beat and
//   rd_data                       beat-valid flags, packed channel data
//   out_vld/sop/eop/ch/data     : tagged output beat stream
//   busy / done / stray_err     : status
//   timeout_err                 : only present when RD_TIMEOUT_EN is defined
// Modports:
//   master : the scheduler side (drives rd_sop, the output stream and status)
//   slave  : the environment side (NPU read port + sink)
// Optional feature macro: RD_TIMEOUT_EN
// -----------------------------------------------------------------------------
interface npu_result_rd_scheduler_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 16,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic                     save_finish;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        rd_sop;
  logic [NUM_CH-1:0]        rd_eop;
  logic [NUM_CH-1:0]        rd_vld;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic                     out_vld;
  logic                     out_sop;
  logic                     out_eop;
  logic [CH_W-1:0]          out_ch;
  logic [DATA_W-1:0]        out_data;
  logic                     busy;
  logic                     done;
  logic                     stray_err;
`ifdef RD_TIMEOUT_EN
  logic                     timeout_err;

  modport master (
    input  save_finish, ch_en, rd_eop, rd_vld, rd_data,
    output rd_sop, out_vld, out_sop, out_eop, out_ch, out_data,
           busy, done, stray_err, timeout_err
  );

  modport slave (
    output save_finish, ch_en, rd_eop, rd_vld, rd_data,
    input  rd_sop, out_vld, out_sop, out_eop, out_ch, out_data,
           busy, done, stray_err, timeout_err
  );
`else
  modport master (
    input  save_finish, ch_en, rd_eop, rd_vld, rd_data,
    output rd_sop, out_vld, out_sop, out_eop, out_ch, out_data,
           busy, done, stray_err
  );

  modport slave (
    output save_finish, ch_en, rd_eop, rd_vld, rd_data,
    input  rd_sop, out_vld, out_sop, out_eop, out_ch, out_data,
           busy, done, stray_err
  );
`endif
endinterface

// File: rtl/npu_result_rd_scheduler.sv
// -----------------------------------------------------------------------------
// npu_result_rd_scheduler
// Sequences readout of the NPU result channels after a computation finishes.
// An accepted save_finish latches the channel enable mask; every enabled
// channel then gets one rd_sop pulse, in ascending order, and its beats are
// forwarded (one cycle later) onto a single tagged output stream. done pulses
// once all enabled channels have delivered their last beat.
//
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : npu_result_rd_scheduler_if.master (see interface header)
//
// Optional feature macro: RD_TIMEOUT_EN
//   Adds a per-channel watchdog; a channel silent for TIMEOUT WAIT cycles is
//   abandoned and the sticky timeout_err flag is raised.
// -----------------------------------------------------------------------------
module npu_result_rd_scheduler #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 16,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int TIMEOUT = 255
) (
  input logic                         clk,
  input logic                         rstn,
  npu_result_rd_scheduler_if.master   bus
);

  if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("npu_result_rd_scheduler: unsupported NUM_CH or TIMEOUT");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
  logic                first_q, first_d;   // next forwarded beat is the channel's first
  logic                stray_q, stray_d;

  logic                out_vld_q, out_sop_q, out_eop_q;
  logic [CH_W-1:0]     out_ch_q;
  logic [DATA_W-1:0]   out_data_q;

  logic                accept;
  logic                cur_vld, cur_eop;
  logic [DATA_W-1:0]   cur_data;
  logic                fwd;
  logic                qual_eop;
  logic                wd_hit;
  logic                adv;
  logic [NUM_CH-1:0]   own_bit;
  logic                stray_hit;
  logic                sel_found;
  logic [CH_W-1:0]     sel_idx;

  // Lowest set bit of m at or above index 'from'; MSB of the result is 'found'.
  // Scanning downward lets the lowest qualifying index overwrite the others.
  function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] m,
                                              input logic [CH_W-1:0]   from);
    logic            found;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) begin
        found = 1'b1;
        idx   = CH_W'(i);
      end
    end
    return {found, idx};
  endfunction

  assign accept   = (state_q == S_IDLE) && bus.save_finish;
  assign cur_vld  = bus.rd_vld[ch_idx_q];
  assign cur_eop  = bus.rd_eop[ch_idx_q];
  assign cur_data = bus.rd_data[ch_idx_q*DATA_W +: DATA_W];
  assign fwd      = (state_q == S_WAIT) && cur_vld;
  // rd_eop only counts when it comes with a valid beat.
  assign qual_eop = fwd && cur_eop;
  assign adv      = qual_eop || wd_hit;

  // Only the active channel may present beats, and only while in WAIT;
  // anything else on rd_vld is a stray beat.
  assign own_bit   = (state_q == S_WAIT) ? (NUM_CH'(1) << ch_idx_q) : '0;
  assign stray_hit = |(bus.rd_vld & ~own_bit);

  assign {sel_found, sel_idx} = find_next(mask_q, ch_idx_q);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      ch_idx_q <= '0;
      first_q  <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ch_idx_q <= ch_idx_d;
      first_q  <= first_d;
      stray_q  <= stray_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_idx_d = ch_idx_q;
    first_d  = first_q;
    stray_d  = stray_q | stray_hit;

    case (state_q)
      S_IDLE: begin
        if (bus.save_finish) begin
          mask_d   = bus.ch_en;
          ch_idx_d = '0;
          stray_d  = 1'b0;
          state_d  = S_SEL;
        end
      end
      S_SEL: begin
        if (sel_found) begin
          ch_idx_d = sel_idx;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_DONE;
        end
      end
      S_ISSUE: begin
        first_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fwd) begin
          first_d = 1'b0;
        end
        if (adv) begin
          mask_d[ch_idx_q] = 1'b0;
          if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
            state_d = S_DONE;
          end else begin
            ch_idx_d = ch_idx_q + 1'b1;
            state_d  = S_SEL;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output stream register: one cycle behind the channel read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_ch_q   <= '0;
      out_data_q <= '0;
    end else begin
      out_vld_q <= fwd;
      out_sop_q <= fwd && first_q;
      out_eop_q <= qual_eop;
      if (fwd) begin
        out_ch_q   <= ch_idx_q;
        out_data_q <= cur_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef RD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;

  // Counter restarts when a channel is issued and on every forwarded beat, so
  // it measures the longest silence within the current channel.
  assign wd_hit = (state_q == S_WAIT) && !fwd && (wd_q == WD_W'(TIMEOUT));

  always_comb begin
    wd_d  = wd_q;
    tmo_d = tmo_q | wd_hit;
    if (state_q == S_ISSUE) begin
      wd_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_d = fwd ? '0 : wd_q + 1'b1;
    end
    if (accept) begin
      tmo_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.timeout_err = tmo_q;
`else
  assign wd_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Status and read-start outputs decode directly from the state register
  // ---------------------------------------------------------------------------
  assign bus.rd_sop    = (state_q == S_ISSUE) ? (NUM_CH'(1) << ch_idx_q) : '0;
  assign bus.busy      = (state_q == S_SEL) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.stray_err = stray_q;

  assign bus.out_vld  = out_vld_q;
  assign bus.out_sop  = out_sop_q;
  assign bus.out_eop  = out_eop_q;
  assign bus.out_ch   = out_ch_q;
  assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_npu_result_rd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_npu_result_rd_scheduler
// Drives save_finish requests and models the NPU channels answering rd_sop
// with bursts of beats. Expected rd_sop order comes from the enable mask
// (ascending enabled channels); expected output beats come from the bursts the
// channel model actually sends, tagged with first/last flags.
// -----------------------------------------------------------------------------
module tb_npu_result_rd_scheduler;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 16;
  localparam int CH_W   = 3;
  localparam int TMO    = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  npu_result_rd_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  npu_result_rd_scheduler #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    int          ch;
    logic [15:0] data;
    bit          sop;
    bit          eop;
  } beat_t;

  int    n_checks = 0;
  int    n_errs   = 0;
  int    beats_seen;
  beat_t exp_q[$];
  int    exp_sop[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.save_finish = 1'b0;
    bus.rd_vld      = '0;
    bus.rd_eop      = '0;
    for (int i = 0; i < NUM_CH; i++) bus.rd_data[i*DATA_W +: DATA_W] = 16'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_sop"}, 32'(bus.rd_sop), 0);
    check({tag, "_stream"}, {bus.out_vld, bus.out_sop, bus.out_eop, bus.out_ch, bus.out_data}, 0);
    check({tag, "_status"}, {bus.busy, bus.done, bus.stray_err}, 0);
  endtask

  // One save_finish request. mode 0: random bursts with gaps; mode 1: 4 beats,
  // data = ch*16+beat; mode 2: channel 3 sends one beat 16'hBEEF.
  // mute: channel that never answers. abort_ch: leave 2 cycles into its WAIT.
  // b2b: leave on the done cycle with save_finish raised.
  task automatic run_txn(input logic [7:0] mask, input int mode, input bit stray,
                         input bit midsf, input int mute, input int abort_ch, input bit b2b);
    int act = -1, left = 0, bnum = 0, abort_cnt = 0;
    bit wait1 = 0, stray_sent = 0, sf_sent = 0, tmo_exp = 0, fin = 0;
    logic [15:0] d;
    beat_t b;
    exp_sop.delete();
    exp_q.delete();
    beats_seen = 0;
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) exp_sop.push_back(i);

    @(negedge clk);
    drive_idle();
    bus.ch_en       = mask;
    bus.save_finish = 1'b1;
    for (int cyc = 1; cyc <= 2000 && !fin; cyc++) begin
      @(negedge clk);
      drive_idle();
      if (cyc == 1) check("busy_after_sf", 32'(bus.busy), 1);

      if (bus.rd_sop != '0) begin
        if (exp_sop.size() == 0) begin
          check("rd_sop_unexpected", 32'(bus.rd_sop), 0);
        end else begin
          act = exp_sop.pop_front();
          check("rd_sop_order", 32'(bus.rd_sop), 32'(1) << act);
          left  = (mode == 1) ? 4 : (mode == 2) ? ((act == 3) ? 1 : 2) : int'($urandom_range(1, 4));
          bnum  = 0;
          wait1 = 1;
          if (act == abort_ch) abort_cnt = 3;
          if (act == mute) begin
            tmo_exp = 1;
            act     = -1;
          end
        end
      end

      if (bus.out_vld) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("out_ch", 32'(bus.out_ch), 32'(b.ch));
          check("out_data", 32'(bus.out_data), 32'(b.data));
          check("out_sop", 32'(bus.out_sop), 32'(b.sop));
          check("out_eop", 32'(bus.out_eop), 32'(b.eop));
        end
      end else if (exp_q.size() != 0) begin
        check("out_missing", 0, 1);
        exp_q.delete();
      end

      if (bus.done) begin
        fin = 1;
        check("done_all_issued", 32'(exp_sop.size()), 0);
        check("done_beats_left", 32'(exp_q.size()), 0);
        check("done_busy_low", 32'(bus.busy), 0);
        check("stray_err", 32'(bus.stray_err), 32'(stray_sent));
`ifdef RD_TIMEOUT_EN
        check("timeout_err", 32'(bus.timeout_err), 32'(tmo_exp));
`endif
        if (mask == 8'h00) check("done_latency", 32'(cyc), 2);
        if (b2b) begin
          bus.ch_en       = 8'hFF;
          bus.save_finish = 1'b1;
        end
      end else begin
        // Stray beat on another channel while the active one is mid-burst.
        if (stray && !stray_sent && act >= 0 && !wait1 && bnum >= 1) begin
          bus.rd_vld[(act + 4) % NUM_CH] = 1'b1;
          stray_sent = 1;
        end
        if (midsf && !sf_sent && act >= 0 && !wait1) begin
          bus.save_finish = 1'b1;
          bus.ch_en       = 8'($urandom);
          sf_sent         = 1;
        end
        if (act >= 0 && left > 0) begin
          if (wait1) begin
            wait1 = 0;
          end else if (mode != 0 || $urandom_range(0, 3) != 0) begin
            d = (mode == 1) ? 16'(act*16 + bnum) :
                (mode == 2 && act == 3) ? 16'hBEEF : 16'($urandom);
            bus.rd_vld[act] = 1'b1;
            bus.rd_eop[act] = (left == 1);
            bus.rd_data[act*DATA_W +: DATA_W] = d;
            exp_q.push_back('{ch: act, data: d, sop: (bnum == 0), eop: (left == 1)});
            bnum++;
            left--;
            if (left == 0) act = -1;
          end else if ($urandom_range(0, 1) == 1) begin
            bus.rd_eop[act] = 1'b1;  // eop without vld must be ignored
          end
        end
        if (abort_cnt > 0) begin
          abort_cnt--;
          if (abort_cnt == 0) return;
        end
      end
    end
    if (!fin) check("txn_cycle_budget", 0, 1);
    if (!b2b) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        drive_idle();
        check("done_single", 32'(bus.done), 0);
      end
    end
  endtask

  initial begin
    bus.ch_en = '0;
    drive_idle();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;

    run_txn(8'hFF, 1, 0, 0, -1, -1, 0);
    check("all_ch_beats", 32'(beats_seen), 32);
    run_txn(8'b1010_0101, 0, 0, 0, -1, -1, 0);
    run_txn(8'h00, 0, 0, 0, -1, -1, 0);
    check("empty_beats", 32'(beats_seen), 0);
    run_txn(8'h08, 2, 0, 0, -1, -1, 0);
    check("single_beat_cnt", 32'(beats_seen), 1);
    run_txn(8'h44, 0, 1, 1, -1, -1, 0);

    // Reset in the middle of channel 4's WAIT, then restart from channel 0.
    run_txn(8'hFF, 1, 0, 0, -1, 4, 0);
    rstn = 1'b0;
    #1;
    check_all_zero("abort");
    drive_idle();
    repeat (2) @(negedge clk);
    check_all_zero("abort_hold");
    rstn = 1'b1;
    run_txn(8'hFF, 0, 0, 0, -1, -1, 0);

    // save_finish on the done cycle is ignored; on the next cycle it is taken.
    run_txn(8'h81, 0, 0, 0, -1, -1, 1);
    @(negedge clk);
    check("b2b_ignored", 32'(bus.busy), 0);
    bus.ch_en       = 8'h00;
    bus.save_finish = 1'b1;
    @(negedge clk);
    bus.save_finish = 1'b0;
    check("b2b_accepted", 32'(bus.busy), 1);
    @(negedge clk);
    check("b2b_done", 32'(bus.done), 1);

`ifdef RD_TIMEOUT_EN
    run_txn(8'h31, 0, 0, 0, 4, -1, 0);
`endif

    repeat (6) run_txn(8'($urandom), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
